pipe_stage_reg: RTL and testbench

//  Generic elastic pipeline stage register with valid/ready handshake, flush and optional skid slot.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/pipe_slot.sv | 23 ++
 rtl/pipe_stage_reg.sv | 62 ++++++
 tb/tb_pipe_stage_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy encoding and default bubble payload for pipeline stage registers
package pipe_pkg;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE = 2'd1;
  localparam logic [1:0] OCC_FULL = 2'd2;
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with valid bit; holds BUBBLE whenever empty so no X leaks downstream
module pipe_slot #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      valid <= 1'b0;
      q <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register with flush, optional skid slot and flush-drop counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SKID = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             flush_i,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] drop_cnt_o
);
  logic v_m, v_s, take, out, main_load, main_clear;
  logic [WIDTH-1:0] skid_q;
  logic [1:0] drops;
  logic [CNT_W:0] sum;
  // With a skid slot ready_o depends only on registered state, breaking the ready_i -> ready_o path
  assign ready_o = ~rst_i & (SKID ? ~v_s : (ready_i | ~v_m));
  assign take = valid_i & ready_o;
  assign out = v_m & ready_i;
  assign main_load = (take & (~v_m | out)) | (out & v_s);
  assign main_clear = flush_i | (out & ~take & ~v_s);
  assign valid_o = v_m;
  assign occ_o = v_s ? OCC_FULL : v_m ? OCC_ONE : OCC_EMPTY;
  assign drops = occ_o - {1'b0, out};
  assign sum = {1'b0, drop_cnt_o} + (CNT_W + 1)'(drops);
  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load(main_load),
    .clear(main_clear),
    .d(v_s ? skid_q : data_i),
    .valid(v_m),
    .q(data_o)
  );
  if (SKID) begin : g_skid
    pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .load(take & v_m & ~out),
      .clear(flush_i | (out & v_s)),
      .d(data_i),
      .valid(v_s),
      .q(skid_q)
    );
  end else begin : g_noskid
    assign v_s = 1'b0;
    assign skid_q = BUBBLE;
  end
  always_ff @(posedge clk_i) begin
    drop_cnt_o <= rst_i ? '0 : flush_i ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : drop_cnt_o;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model checks of pipe_stage_reg in skid, no-skid and narrow-counter builds
module tb_pipe_stage_reg;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vi[3], ri[3], fl[3], ro[3], vo[3], hold[3];
  logic [31:0] di[3], dout[3], cnt[3];
  logic [1:0] occ[3];
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  task automatic ck(input string n, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", n, g, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Instance 0: skid build, instance 1: single-entry build, instance 2: skid build with 2-bit counter
  for (genvar g = 0; g < 3; g++) begin : m
    localparam bit SK = (g != 1);
    localparam int CW = (g == 2) ? 2 : 8;
    localparam logic [31:0] BUB = (g == 2) ? 32'h0 : RV32_NOP;
    logic [CW-1:0] dc;
    logic [31:0] q[$];
    int dcnt = 0;
    pipe_stage_reg #(.WIDTH(32), .SKID(SK), .BUBBLE(BUB), .CNT_W(CW)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .valid_i(vi[g]),
      .ready_o(ro[g]),
      .data_i(di[g]),
      .valid_o(vo[g]),
      .ready_i(ri[g]),
      .data_o(dout[g]),
      .flush_i(fl[g]),
      .occ_o(occ[g]),
      .drop_cnt_o(dc)
    );
    assign cnt[g] = 32'(dc);
    initial forever begin
      bit r, tin, tout;
      @(posedge clk);
      r = !rst && (SK ? q.size() < 2 : (ri[g] || q.size() == 0));
      tin = vi[g] && r;
      tout = q.size() > 0 && ri[g];
      if (rst) begin
        q.delete();
        dcnt = 0;
      end else if (fl[g]) begin
        dcnt = dcnt + q.size() - int'(tout);
        if (dcnt > (1 << CW) - 1) dcnt = (1 << CW) - 1;
        q.delete();
      end else begin
        if (tout) void'(q.pop_front());
        if (tin) q.push_back(di[g]);
      end
    end
    initial forever begin
      @(negedge clk);
      hold[g] = vi[g] && !ro[g];
      if (armed) begin
        ck("valid_o", g, 32'(vo[g]), 32'(q.size() > 0));
        ck("data_o", g, dout[g], q.size() > 0 ? q[0] : BUB);
        ck("occ_o", g, 32'(occ[g]), q.size());
        ck("drop_cnt_o", g, cnt[g], dcnt);
        ck("ready_o", g, 32'(ro[g]), 32'(!rst && (SK ? q.size() < 2 : (ri[g] || q.size() == 0))));
      end
    end
  end
  initial begin
    for (int k = 0; k < 3; k++) begin
      vi[k] = 1'b0;
      ri[k] = 1'b1;
      fl[k] = 1'b0;
      di[k] = '0;
    end
    @(posedge clk);
    #1 armed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ck("rst valid", 0, 32'(vo[0]), 0);
    ck("rst data", 0, dout[0], RV32_NOP);
    ck("rst occ", 0, 32'(occ[0]), 0);
    ck("rst cnt", 0, cnt[0], 0);
    ck("rst ready", 0, 32'(ro[0]), 0);
    cyc();
    rst = 1'b0;
    vi[0] = 1'b1;
    di[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    ck("t1 ready", 0, 32'(ro[0]), 1);
    cyc();
    vi[0] = 1'b0;
    @(negedge clk);
    ck("t1 valid", 0, 32'(vo[0]), 1);
    ck("t1 data", 0, dout[0], 32'hDEAD_BEEF);
    ck("t1 occ", 0, 32'(occ[0]), 1);
    cyc();
    @(negedge clk);
    ck("t1 drained occ", 0, 32'(occ[0]), 0);
    ck("t1 drained data", 0, dout[0], RV32_NOP);
    for (int i = 0; i < 16; i++) begin
      cyc();
      vi[0] = 1'b1;
      di[0] = i;
      @(negedge clk);
      ck("stream ready", 0, 32'(ro[0]), 1);
      if (i > 0) ck("stream data", 0, dout[0], i - 1);
    end
    cyc();
    vi[0] = 1'b0;
    @(negedge clk);
    ck("stream last", 0, dout[0], 15);
    cyc();
    vi[0] = 1'b1;
    di[0] = 1;
    cyc();
    ri[0] = 1'b0;
    di[0] = 2;
    @(negedge clk);
    ck("stall first", 0, dout[0], 1);
    cyc();
    di[0] = 3;
    @(negedge clk);
    ck("stall occ", 0, 32'(occ[0]), 2);
    ck("stall ready", 0, 32'(ro[0]), 0);
    ck("stall data", 0, dout[0], 1);
    cyc();
    @(negedge clk);
    ck("stall hold", 0, dout[0], 1);
    cyc();
    ri[0] = 1'b1;
    cyc();
    @(negedge clk);
    ck("release 2", 0, dout[0], 2);
    ck("release occ", 0, 32'(occ[0]), 1);
    cyc();
    vi[0] = 1'b0;
    @(negedge clk);
    ck("release 3", 0, dout[0], 3);
    cyc();
    vi[0] = 1'b1;
    di[0] = 7;
    ri[0] = 1'b0;
    cyc();
    di[0] = 8;
    cyc();
    di[0] = 9;
    fl[0] = 1'b1;
    @(negedge clk);
    ck("pre-flush occ", 0, 32'(occ[0]), 2);
    cyc();
    fl[0] = 1'b0;
    vi[0] = 1'b0;
    ri[0] = 1'b1;
    @(negedge clk);
    ck("flush valid", 0, 32'(vo[0]), 0);
    ck("flush data", 0, dout[0], RV32_NOP);
    ck("flush occ", 0, 32'(occ[0]), 0);
    ck("flush cnt", 0, cnt[0], 2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      vi[2] = 1'b1;
      di[2] = k;
      ri[2] = 1'b0;
      cyc();
      di[2] = k + 10;
      cyc();
      vi[2] = 1'b0;
      fl[2] = 1'b1;
      cyc();
      fl[2] = 1'b0;
      @(negedge clk);
      ck("sat cnt", 2, cnt[2], k == 0 ? 2 : 3);
    end
    ri[2] = 1'b1;
    cyc();
    rst = 1'b1;
    fl[0] = 1'b1;
    cyc();
    rst = 1'b0;
    fl[0] = 1'b0;
    @(negedge clk);
    ck("rst+flush cnt", 0, cnt[0], 0);
    for (int c = 0; c < 10000; c++) begin
      cyc();
      rst = $urandom_range(0, 999) == 0;
      for (int k = 0; k < 3; k++) begin
        if (!hold[k]) begin
          vi[k] = $urandom_range(0, 3) != 0;
          di[k] = $urandom;
        end
        ri[k] = $urandom_range(0, 3) != 0;
        fl[k] = $urandom_range(0, 39) == 0;
      end
    end
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vi[k] = 1'b0;
      ri[k] = 1'b1;
      fl[k] = 1'b0;
    end
    repeat (4) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
